// File: rtl/alu_pkg.sv
// Shared constants and types for the RV32I ALU issue controller.
// Optional SLT/SLTU decode is enabled by defining ALU_ISSUE_SLT_EN.
package alu_pkg;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  localparam logic [2:0] ALU_ADD   = 3'b000;
  localparam logic [2:0] ALU_SUB   = 3'b001;
  localparam logic [2:0] ALU_ANDOR = 3'b010;
  localparam logic [2:0] ALU_XOR   = 3'b011;
  localparam logic [2:0] ALU_SRA   = 3'b100;
  localparam logic [2:0] ALU_SLA   = 3'b101;
  localparam logic [2:0] ALU_SRL   = 3'b110;
  localparam logic [2:0] ALU_SLL   = 3'b111;

  localparam int FLAG_N = 0;
  localparam int FLAG_Z = 1;
  localparam int FLAG_V = 2;
  localparam int FLAG_C = 3;

  typedef enum logic [3:0] {
    KIND_ALU, KIND_SLT, KIND_SLTU,
    KIND_BEQ, KIND_BNE, KIND_BLT, KIND_BGE, KIND_BLTU, KIND_BGEU
  } kind_e;

  typedef enum logic [1:0] {ST_IDLE, ST_EXEC, ST_DONE} state_e;

endpackage

// File: rtl/alu_issue_ctrl_if.sv
// Instruction-in and writeback-record-out handshake bundle of alu_issue_ctrl.
interface alu_issue_ctrl_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] instr;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic        out_valid;
  logic        out_ready;
  logic [4:0]  rd_addr;
  logic [31:0] rd_data;
  logic        rd_we;
  logic        branch_taken;
  logic        illegal;

  modport master (
    output in_valid, instr, rs1_data, rs2_data, out_ready,
    input  in_ready, out_valid, rd_addr, rd_data, rd_we, branch_taken, illegal
  );

  modport slave (
    input  in_valid, instr, rs1_data, rs2_data, out_ready,
    output in_ready, out_valid, rd_addr, rd_data, rd_we, branch_taken, illegal
  );
endinterface

// File: rtl/alu_issue_decode.sv
// Combinational RV32I OP/OP-IMM/BRANCH decode into ALU controls and operands.
// SLT/SLTU/SLTI/SLTIU are legal only when ALU_ISSUE_SLT_EN is defined.
module alu_issue_decode
  import alu_pkg::*;
(
  input  logic [31:0] instr_i,
  input  logic [31:0] rs1_data_i,
  input  logic [31:0] rs2_data_i,
  output logic [2:0]  alu_control_o,
  output logic        alu_sign_o,
  output logic [31:0] src_a_o,
  output logic [31:0] src_b_o,
  output logic [4:0]  rd_o,
  output kind_e       kind_o,
  output logic        illegal_o
);
  logic [6:0]  opcode;
  logic [6:0]  funct7;
  logic [2:0]  funct3;
  logic [31:0] imm_i;
  logic [31:0] shamt;
  logic        unused_rs1_field;

  assign opcode           = instr_i[6:0];
  assign funct3           = instr_i[14:12];
  assign funct7           = instr_i[31:25];
  assign imm_i            = {{20{instr_i[31]}}, instr_i[31:20]};
  assign shamt            = {27'b0, instr_i[24:20]};
  assign unused_rs1_field = ^instr_i[19:15];

  always_comb begin
    alu_control_o = ALU_ADD;
    alu_sign_o    = 1'b0;
    src_a_o       = rs1_data_i;
    src_b_o       = rs2_data_i;
    rd_o          = instr_i[11:7];
    kind_o        = KIND_ALU;
    illegal_o     = 1'b0;
    case (opcode)
      OPC_OP: begin
        // funct7=0100000 only qualifies SUB and SRA
        if (funct7 != 7'b0 && !(funct7 == 7'b0100000 && (funct3 == 3'b000 || funct3 == 3'b101)))
          illegal_o = 1'b1;
        case (funct3)
          3'b000: alu_control_o = funct7[5] ? ALU_SUB : ALU_ADD;
          3'b001: alu_control_o = ALU_SLL;
`ifdef ALU_ISSUE_SLT_EN
          3'b010: begin alu_control_o = ALU_SUB; kind_o = KIND_SLT;  end
          3'b011: begin alu_control_o = ALU_SUB; kind_o = KIND_SLTU; end
`else
          3'b010, 3'b011: illegal_o = 1'b1;
`endif
          3'b100: alu_control_o = ALU_XOR;
          3'b101: alu_control_o = funct7[5] ? ALU_SRA : ALU_SRL;
          3'b110: begin alu_control_o = ALU_ANDOR; alu_sign_o = 1'b1; end
          default: alu_control_o = ALU_ANDOR;
        endcase
      end
      OPC_OP_IMM: begin
        src_b_o = imm_i;
        case (funct3)
          3'b000: alu_control_o = ALU_ADD;
          3'b001: begin
            src_b_o = shamt; alu_sign_o = 1'b1; alu_control_o = ALU_SLL;
            if (funct7 != 7'b0) illegal_o = 1'b1;
          end
`ifdef ALU_ISSUE_SLT_EN
          3'b010: begin alu_control_o = ALU_SUB; kind_o = KIND_SLT;  end
          3'b011: begin alu_control_o = ALU_SUB; kind_o = KIND_SLTU; end
`else
          3'b010, 3'b011: illegal_o = 1'b1;
`endif
          3'b100: alu_control_o = ALU_XOR;
          3'b101: begin
            src_b_o = shamt; alu_sign_o = 1'b1;
            alu_control_o = funct7[5] ? ALU_SRA : ALU_SRL;
            if (funct7 != 7'b0 && funct7 != 7'b0100000) illegal_o = 1'b1;
          end
          3'b110: begin alu_control_o = ALU_ANDOR; alu_sign_o = 1'b1; end
          default: alu_control_o = ALU_ANDOR;
        endcase
      end
      OPC_BRANCH: begin
        alu_control_o = ALU_SUB;
        rd_o          = 5'd0;
        case (funct3)
          3'b000:  kind_o = KIND_BEQ;
          3'b001:  kind_o = KIND_BNE;
          3'b100:  kind_o = KIND_BLT;
          3'b101:  kind_o = KIND_BGE;
          3'b110:  kind_o = KIND_BLTU;
          3'b111:  kind_o = KIND_BGEU;
          default: illegal_o = 1'b1;
        endcase
      end
      default: illegal_o = 1'b1;
    endcase
    // Illegal encodings leave the ALU inputs quiet
    if (illegal_o) begin
      alu_control_o = ALU_ADD;
      alu_sign_o    = 1'b0;
      src_a_o       = 32'd0;
      src_b_o       = 32'd0;
      rd_o          = 5'd0;
      kind_o        = KIND_ALU;
    end
  end
endmodule

// File: rtl/alu_issue_ctrl.sv
// Issues one decoded RV32I instruction to an external ALU, waits, captures
// result/flags and emits a writeback/branch record. Option: ALU_ISSUE_SLT_EN.
module alu_issue_ctrl
  import alu_pkg::*;
#(
  parameter int ALU_WAIT_CYCLES = 1,
  parameter int XLEN            = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  alu_issue_ctrl_if.slave  bus,
  output logic [XLEN-1:0]  src_a_o,
  output logic [XLEN-1:0]  src_b_o,
  output logic [2:0]       alu_control_o,
  output logic             alu_sign_o,
  input  logic [XLEN-1:0]  alu_result_i,
  input  logic [3:0]       alu_flags_i
);
  localparam int CNT_W = (ALU_WAIT_CYCLES < 2) ? 1 : $clog2(ALU_WAIT_CYCLES + 1);

  if (ALU_WAIT_CYCLES < 1 || XLEN != 32) begin : g_bad_param
    $error("alu_issue_ctrl: ALU_WAIT_CYCLES must be >= 1 and XLEN must be 32");
  end

  state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0] src_a_q, src_a_d, src_b_q, src_b_d;
  logic [2:0]  ctrl_q, ctrl_d;
  logic        sign_q, sign_d;
  logic [4:0]  rd_q, rd_d;
  kind_e       kind_q, kind_d;
  logic [4:0]  rd_addr_q, rd_addr_d;
  logic [31:0] rd_data_q, rd_data_d;
  logic        rd_we_q, rd_we_d, taken_q, taken_d, illegal_q, illegal_d;

  logic [2:0]  dec_ctrl;
  logic        dec_sign, dec_illegal;
  logic [31:0] dec_src_a, dec_src_b;
  logic [4:0]  dec_rd;
  kind_e       dec_kind;

  alu_issue_decode u_decode (
    .instr_i       (bus.instr),
    .rs1_data_i    (bus.rs1_data),
    .rs2_data_i    (bus.rs2_data),
    .alu_control_o (dec_ctrl),
    .alu_sign_o    (dec_sign),
    .src_a_o       (dec_src_a),
    .src_b_o       (dec_src_b),
    .rd_o          (dec_rd),
    .kind_o        (dec_kind),
    .illegal_o     (dec_illegal)
  );

  logic        lt_signed;
  logic [31:0] cap_data;
  logic        cap_we, cap_taken;

  assign lt_signed = alu_flags_i[FLAG_N] ^ alu_flags_i[FLAG_V];

  always_comb begin
    cap_data  = alu_result_i;
    cap_we    = (rd_q != 5'd0);
    cap_taken = 1'b0;
    case (kind_q)
`ifdef ALU_ISSUE_SLT_EN
      KIND_SLT:  cap_data = {31'b0, lt_signed};
      KIND_SLTU: cap_data = {31'b0, alu_flags_i[FLAG_C]};
`endif
      KIND_BEQ:  begin cap_data = '0; cap_we = 1'b0; cap_taken =  alu_flags_i[FLAG_Z]; end
      KIND_BNE:  begin cap_data = '0; cap_we = 1'b0; cap_taken = !alu_flags_i[FLAG_Z]; end
      KIND_BLT:  begin cap_data = '0; cap_we = 1'b0; cap_taken =  lt_signed; end
      KIND_BGE:  begin cap_data = '0; cap_we = 1'b0; cap_taken = !lt_signed; end
      KIND_BLTU: begin cap_data = '0; cap_we = 1'b0; cap_taken =  alu_flags_i[FLAG_C]; end
      KIND_BGEU: begin cap_data = '0; cap_we = 1'b0; cap_taken = !alu_flags_i[FLAG_C]; end
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;  cnt_d = cnt_q;
    src_a_d = src_a_q;  src_b_d = src_b_q;  ctrl_d = ctrl_q;  sign_d = sign_q;
    rd_d = rd_q;        kind_d = kind_q;
    rd_addr_d = rd_addr_q;  rd_data_d = rd_data_q;  rd_we_d = rd_we_q;
    taken_d = taken_q;      illegal_d = illegal_q;
    case (state_q)
      ST_IDLE: if (bus.in_valid) begin
        src_a_d = dec_src_a;  src_b_d = dec_src_b;  ctrl_d = dec_ctrl;  sign_d = dec_sign;
        rd_d    = dec_rd;     kind_d  = dec_kind;
        if (dec_illegal) begin
          rd_addr_d = 5'd0;  rd_data_d = '0;  rd_we_d = 1'b0;
          taken_d   = 1'b0;  illegal_d = 1'b1;
          state_d   = ST_DONE;
        end else begin
          cnt_d   = CNT_W'(ALU_WAIT_CYCLES);
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          rd_addr_d = rd_q;     rd_data_d = cap_data;  rd_we_d = cap_we;
          taken_d   = cap_taken; illegal_d = 1'b0;
          state_d   = ST_DONE;
        end
      end
      ST_DONE: if (bus.out_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;  cnt_q <= '0;
      src_a_q <= '0;  src_b_q <= '0;  ctrl_q <= '0;  sign_q <= 1'b0;
      rd_q <= '0;     kind_q <= KIND_ALU;
      rd_addr_q <= '0;  rd_data_q <= '0;  rd_we_q <= 1'b0;
      taken_q <= 1'b0;  illegal_q <= 1'b0;
    end else begin
      state_q <= state_d;  cnt_q <= cnt_d;
      src_a_q <= src_a_d;  src_b_q <= src_b_d;  ctrl_q <= ctrl_d;  sign_q <= sign_d;
      rd_q <= rd_d;        kind_q <= kind_d;
      rd_addr_q <= rd_addr_d;  rd_data_q <= rd_data_d;  rd_we_q <= rd_we_d;
      taken_q <= taken_d;      illegal_q <= illegal_d;
    end
  end

  assign bus.in_ready     = (state_q == ST_IDLE) && !rst_i;
  assign bus.out_valid    = (state_q == ST_DONE);
  assign bus.rd_addr      = rd_addr_q;
  assign bus.rd_data      = rd_data_q;
  assign bus.rd_we        = rd_we_q;
  assign bus.branch_taken = taken_q;
  assign bus.illegal      = illegal_q;
  assign src_a_o          = src_a_q;
  assign src_b_o          = src_b_q;
  assign alu_control_o    = ctrl_q;
  assign alu_sign_o       = sign_q;
endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl: ISA reference model feeds a scoreboard queue;
// records are popped and compared when out_valid appears. Honours ALU_ISSUE_SLT_EN.
`timescale 1ns/1ps
module tb_alu_issue_ctrl;
  localparam int WAIT = 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rst3 = 1'b1;
  always #5 clk = ~clk;

  alu_issue_ctrl_if bus();
  alu_issue_ctrl_if bus3();

  logic [31:0] src_a, src_b, alu_res, src_a3, src_b3, alu_res3;
  logic [2:0]  alu_ctrl, alu_ctrl3;
  logic        alu_sign, alu_sign3;
  logic [3:0]  alu_flags, alu_flags3;

  alu_issue_ctrl #(.ALU_WAIT_CYCLES(WAIT)) u_dut (
    .clk_i(clk), .rst_i(rst), .bus(bus.slave),
    .src_a_o(src_a), .src_b_o(src_b), .alu_control_o(alu_ctrl), .alu_sign_o(alu_sign),
    .alu_result_i(alu_res), .alu_flags_i(alu_flags)
  );

  alu_issue_ctrl #(.ALU_WAIT_CYCLES(3)) u_dut3 (
    .clk_i(clk), .rst_i(rst3), .bus(bus3.slave),
    .src_a_o(src_a3), .src_b_o(src_b3), .alu_control_o(alu_ctrl3), .alu_sign_o(alu_sign3),
    .alu_result_i(alu_res3), .alu_flags_i(alu_flags3)
  );

  // External ALU: flags {C,V,Z,N}, C is borrow on subtract
  function automatic logic [35:0] alu_model(input logic [31:0] a, input logic [31:0] b,
                                            input logic [2:0] op, input logic sg);
    logic [32:0] wide;
    logic [31:0] r;
    logic        c, v;
    wide = '0; c = 1'b0; v = 1'b0;
    case (op)
      3'b000: begin
        wide = {1'b0, a} + {1'b0, b}; r = wide[31:0]; c = wide[32];
        v = (a[31] == b[31]) && (r[31] != a[31]);
      end
      3'b001: begin r = a - b; c = (a < b); v = (a[31] != b[31]) && (r[31] != a[31]); end
      3'b010: r = sg ? (a | b) : (a & b);
      3'b011: r = a ^ b;
      3'b100: r = $signed(a) >>> b[4:0];
      3'b101: r = a << b[4:0];
      3'b110: r = a >> b[4:0];
      default: r = a << b[4:0];
    endcase
    return {c, v, (r == 32'd0), r[31], r};
  endfunction

  always_comb {alu_flags, alu_res}   = alu_model(src_a, src_b, alu_ctrl, alu_sign);
  always_comb {alu_flags3, alu_res3} = alu_model(src_a3, src_b3, alu_ctrl3, alu_sign3);

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
    logic        we;
    logic        taken;
    logic        illegal;
  } rec_t;

  rec_t exp_q[$];
  int checks = 0;
  int errors = 0;

  // Architectural RV32I meaning of an instruction, independent of ALU encoding
  function automatic rec_t ref_rec(input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b);
    rec_t e;
    logic [6:0] op, f7;
    logic [2:0] f3;
    logic [31:0] y;
    logic ok;
    e = '0; ok = 1'b1;
    op = ins[6:0]; f3 = ins[14:12]; f7 = ins[31:25];
    if (op == 7'h33 || op == 7'h13) begin
      y = (op == 7'h33) ? b : {{20{ins[31]}}, ins[31:20]};
      if (op == 7'h33 && !(f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5)))) ok = 1'b0;
      if (op == 7'h13 && f3 == 3'd1 && f7 != 7'h00) ok = 1'b0;
      if (op == 7'h13 && f3 == 3'd5 && f7 != 7'h00 && f7 != 7'h20) ok = 1'b0;
      case (f3)
        3'd0: e.data = (op == 7'h33 && f7[5]) ? a - y : a + y;
        3'd1: e.data = a << y[4:0];
        3'd2: begin
          e.data = {31'b0, $signed(a) < $signed(y)};
`ifndef ALU_ISSUE_SLT_EN
          ok = 1'b0;
`endif
        end
        3'd3: begin
          e.data = {31'b0, a < y};
`ifndef ALU_ISSUE_SLT_EN
          ok = 1'b0;
`endif
        end
        3'd4: e.data = a ^ y;
        3'd5: if (f7[5]) e.data = $signed(a) >>> y[4:0]; else e.data = a >> y[4:0];
        3'd6: e.data = a | y;
        default: e.data = a & y;
      endcase
      e.rd = ins[11:7];
      e.we = (e.rd != 5'd0);
    end else if (op == 7'h63) begin
      case (f3)
        3'd0: e.taken = (a == b);
        3'd1: e.taken = (a != b);
        3'd4: e.taken = ($signed(a) < $signed(b));
        3'd5: e.taken = !($signed(a) < $signed(b));
        3'd6: e.taken = (a < b);
        3'd7: e.taken = !(a < b);
        default: ok = 1'b0;
      endcase
    end else begin
      ok = 1'b0;
    end
    if (!ok) begin e = '0; e.illegal = 1'b1; end
    return e;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic run_op(input string tag, input logic [31:0] ins, input logic [31:0] a,
                        input logic [31:0] b, input int hold, input bit chk_dec,
                        input logic [2:0] e_ctrl, input logic e_sign, input logic [31:0] e_srcb);
    rec_t e, got;
    int   n;
    bit   seen;
    exp_q.push_back(ref_rec(ins, a, b));
    @(negedge clk);
    bus.in_valid = 1'b1; bus.instr = ins; bus.rs1_data = a; bus.rs2_data = b;
    n = 0;
    while (!bus.in_ready && n < 20) begin @(negedge clk); n++; end
    chk({tag, " in_ready"}, 64'(bus.in_ready), 64'd1);
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    n = 0; seen = 1'b0;
    while (!seen && n < 20) begin
      @(negedge clk); n++;
      if (chk_dec && n == 1) begin
        chk({tag, " alu_control"}, 64'(alu_ctrl), 64'(e_ctrl));
        chk({tag, " alu_sign"}, 64'(alu_sign), 64'(e_sign));
        chk({tag, " src_b"}, 64'(src_b), 64'(e_srcb));
      end
      if (bus.out_valid) seen = 1'b1;
    end
    e = exp_q.pop_front();
    chk({tag, " latency"}, 64'(n), e.illegal ? 64'd1 : 64'(WAIT + 1));
    got.rd = bus.rd_addr; got.data = bus.rd_data; got.we = bus.rd_we;
    got.taken = bus.branch_taken; got.illegal = bus.illegal;
    $display("txn %s instr=%h rs1=%h rs2=%h rd=%0d data=%h we=%0b taken=%0b illegal=%0b",
             tag, ins, a, b, got.rd, got.data, got.we, got.taken, got.illegal);
    chk({tag, " record"}, 64'(got), 64'(e));
    for (int i = 0; i < hold; i++) begin
      bus.in_valid = 1'b1; bus.instr = 32'h00100093;
      @(negedge clk);
      got.rd = bus.rd_addr; got.data = bus.rd_data; got.we = bus.rd_we;
      got.taken = bus.branch_taken; got.illegal = bus.illegal;
      chk({tag, " hold out_valid"}, 64'(bus.out_valid), 64'd1);
      chk({tag, " hold in_ready"}, 64'(bus.in_ready), 64'd0);
      chk({tag, " hold record"}, 64'(got), 64'(e));
    end
    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    @(posedge clk);
    #1 bus.out_ready = 1'b0;
    @(negedge clk);
    chk({tag, " post out_valid"}, 64'(bus.out_valid), 64'd0);
    chk({tag, " post in_ready"}, 64'(bus.in_ready), 64'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] ra, rb, ins;
    bus.in_valid = 1'b0; bus.instr = '0; bus.rs1_data = '0; bus.rs2_data = '0; bus.out_ready = 1'b0;
    bus3.in_valid = 1'b0; bus3.instr = '0; bus3.rs1_data = '0; bus3.rs2_data = '0; bus3.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset out_valid", 64'(bus.out_valid), 64'd0);
    chk("reset in_ready", 64'(bus.in_ready), 64'd0);
    chk("reset src_a", 64'(src_a), 64'd0);
    chk("reset rd_data", 64'(bus.rd_data), 64'd0);
    chk("reset illegal", 64'(bus.illegal), 64'd0);
    rst = 1'b0; rst3 = 1'b0;
    #1 chk("release in_ready", 64'(bus.in_ready), 64'd1);

    run_op("addi_m1", 32'hFFF00293, 32'd0, 32'd0, 0, 1'b1, 3'b000, 1'b0, 32'hFFFFFFFF);
    run_op("blt",  32'h0020C063, 32'hFFFFFFFF, 32'd1, 0, 1'b1, 3'b001, 1'b0, 32'd1);
    run_op("bltu", 32'h0020E063, 32'hFFFFFFFF, 32'd1, 0, 1'b0, 3'b000, 1'b0, 32'd0);
    run_op("beq",  32'h00208063, 32'd7, 32'd7, 0, 1'b0, 3'b000, 1'b0, 32'd0);
    run_op("bge",  32'h0020D063, 32'd3, 32'hFFFFFFF0, 0, 1'b0, 3'b000, 1'b0, 32'd0);
    run_op("bne",  32'h00209063, 32'd5, 32'd5, 0, 1'b0, 3'b000, 1'b0, 32'd0);
    run_op("srai", 32'h40415093, 32'h80000000, 32'd0, 0, 1'b1, 3'b100, 1'b1, 32'd4);
    run_op("srli", 32'h00415093, 32'h80000000, 32'd0, 0, 1'b1, 3'b110, 1'b1, 32'd4);
    run_op("add_hold", 32'h002081B3, 32'd10, 32'd20, 5, 1'b0, 3'b000, 1'b0, 32'd0);
    run_op("sub",  32'h402081B3, 32'd5, 32'd9, 0, 1'b1, 3'b001, 1'b0, 32'd9);
    run_op("or",   32'h0020E233, 32'h0F0F0000, 32'h000000FF, 0, 1'b1, 3'b010, 1'b1, 32'h000000FF);
    run_op("and",  32'h0020F233, 32'h0F0F00F0, 32'h000000FF, 0, 1'b0, 3'b000, 1'b0, 32'd0);
    run_op("addi_x0", 32'h00100013, 32'd0, 32'd0, 0, 1'b0, 3'b000, 1'b0, 32'd0);
    run_op("illegal_opc", 32'h0000007F, 32'd1, 32'd2, 2, 1'b0, 3'b000, 1'b0, 32'd0);
    run_op("illegal_f7", 32'h022081B3, 32'd1, 32'd2, 0, 1'b0, 3'b000, 1'b0, 32'd0);
    run_op("illegal_br", 32'h0020A063, 32'd1, 32'd2, 0, 1'b0, 3'b000, 1'b0, 32'd0);
    run_op("slti", 32'h0020A313, 32'd1, 32'd0, 0, 1'b0, 3'b000, 1'b0, 32'd0);
    run_op("sltu", 32'h0020B333, 32'd9, 32'd3, 0, 1'b0, 3'b000, 1'b0, 32'd0);

    for (int k = 0; k < 8; k++) begin
      ra = $urandom; rb = $urandom;
      case (k % 4)
        0: ins = 32'h00208033;
        1: ins = 32'h40208033;
        2: ins = 32'h0020C033;
        default: ins = 32'h00209033;
      endcase
      ins[11:7] = 5'($urandom_range(0, 31));
      run_op("rand", ins, ra, rb, int'($urandom_range(0, 2)), 1'b0, 3'b000, 1'b0, 32'd0);
    end

    // Abort mid-EXEC on the WAIT=3 instance
    @(negedge clk);
    bus3.in_valid = 1'b1; bus3.instr = 32'h002081B3; bus3.rs1_data = 32'd1; bus3.rs2_data = 32'd2;
    @(posedge clk);
    #1 bus3.in_valid = 1'b0;
    @(negedge clk);
    chk("rst3 exec src_a", 64'(src_a3), 64'd1);
    chk("rst3 exec in_ready", 64'(bus3.in_ready), 64'd0);
    @(negedge clk);
    #1 rst3 = 1'b1;
    #1;
    chk("rst3 src_a", 64'(src_a3), 64'd0);
    chk("rst3 src_b", 64'(src_b3), 64'd0);
    chk("rst3 alu_control", 64'(alu_ctrl3), 64'd0);
    chk("rst3 out_valid", 64'(bus3.out_valid), 64'd0);
    chk("rst3 in_ready", 64'(bus3.in_ready), 64'd0);
    chk("rst3 record", 64'({bus3.rd_addr, bus3.rd_data, bus3.rd_we, bus3.branch_taken, bus3.illegal}), 64'd0);
    @(negedge clk);
    rst3 = 1'b0;
    @(posedge clk);
    #1 chk("rst3 release in_ready", 64'(bus3.in_ready), 64'd1);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk("rst3 no record", 64'(bus3.out_valid), 64'd0);
    end
    $display("txn rst3_abort out_valid=%0b in_ready=%0b", bus3.out_valid, bus3.in_ready);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
